// File: rtl/hyperbus_pkg.sv
// Shared types and defaults for the HyperBus read-data capture path.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CAPT = 3'b010,
        ST_DONE = 3'b100
    } cap_state_t;

    localparam logic [1:0] RWDS_STROBE = 2'b01;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/hyperbus_rfifo.sv
// Synchronous word FIFO; head entry is read straight from the register array.
module hyperbus_rfifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hyperbus_rdcap.sv
// Read-data capture: qualifies DDR beats by RWDS, packs beat pairs into words
// and streams them out through a small FIFO, with timeout/overflow tracking.
module hyperbus_rdcap
    import hyperbus_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk90,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   burst_len,
    input  logic               abort,
    input  logic [2*WIDTH-1:0] ddr_dat,
    input  logic [1:0]         ddr_rwds,
    output logic [4*WIDTH-1:0] m_dat,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic               overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);

    cap_state_t                 state;
    logic [LEN_W-1:0]           word_cnt;
    logic [TW-1:0]              tmo_cnt;
    logic                       half;
    logic [2*WIDTH-1:0]         hold;

    logic                       qual, push, pop, drop;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       unused_count;

    assign qual         = (ddr_rwds == RWDS_STROBE);
    assign push         = (state == ST_CAPT) && !abort && qual && half;
    assign pop          = m_ready && !fifo_empty;
    assign drop         = push && fifo_full && !pop;
    assign m_valid      = !fifo_empty;
    assign unused_count = ^fifo_count;

    hyperbus_rfifo #(
        .DATA_W (4*WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk90),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({hold, ddr_dat}),
        .dout  (m_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            half        <= 1'b0;
            hold        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_cnt    <= burst_len;
                        tmo_cnt     <= TW'(TIMEOUT);
                        half        <= 1'b0;
                        timeout_err <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (drop) overflow <= 1'b1;
                    // Abort wins over a beat arriving in the same cycle.
                    if (abort) begin
                        half  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (qual) begin
                        tmo_cnt <= TW'(TIMEOUT);
                        if (!half) begin
                            hold <= ddr_dat;
                            half <= 1'b1;
                        end else begin
                            half     <= 1'b0;
                            word_cnt <= word_cnt - 1'b1;
                            if (word_cnt == '0) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end else if (tmo_cnt <= TW'(1)) begin
                        tmo_cnt     <= '0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
